// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner: FSM states, code width and key map.
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} scan_state_t;

    localparam logic [7:0] KEY_STAR = 8'hA;
    localparam logic [7:0] KEY_HASH = 8'hB;

    function automatic int code_w_of(input int rows, input int cols);
        int w;
        w = $clog2(rows * cols);
        return (w < 4) ? 4 : w;
    endfunction

    // The 4x3 phone pad carries digits; any other geometry is numbered row-major.
    function automatic logic [7:0] code_of(input int r, input int c, input int rows, input int cols);
        logic [7:0] code;
        if (rows == 4 && cols == 3) begin
            if (r < 3)       code = 8'(r * 3 + c + 1);
            else if (c == 0) code = KEY_STAR;
            else if (c == 1) code = 8'd0;
            else             code = KEY_HASH;
        end else begin
            code = 8'(r * cols + c);
        end
        return code;
    endfunction

endpackage

// File: rtl/key_fifo.sv
// First-word-fall-through key-code buffer; the caller guarantees no write when full without a read.
module key_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is data only and carries no reset; the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign dout  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad front end: row scan, press/release debounce, key-code FIFO and CPU interrupt.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS            = 4,
    parameter int COLS            = 3,
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int FIFO_DEPTH      = 4,
    localparam int CODE_W = code_w_of(ROWS, COLS),
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [COLS-1:0]   COL_IN,
    output logic [ROWS-1:0]   ROW_OUT,
    output logic [CODE_W-1:0] KEY_CODE,
    output logic              KEY_VALID,
    input  logic              KEY_ACK,
    output logic              INTERUPT,
    output logic [CNT_W-1:0]  FIFO_COUNT,
    output logic              OVERFLOW,
    input  logic              OVF_CLR
);

    localparam int RW    = $clog2(ROWS);
    localparam int CW    = $clog2(COLS);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);

    logic [COLS-1:0]   col_p0, col_p1;
    scan_state_t       state, state_nx;
    logic [RW-1:0]     row, row_nx, row_adv;
    logic [CW-1:0]     col, col_nx, hit_col;
    logic [DIV_W-1:0]  div_cnt, div_nx;
    logic [DEB_W-1:0]  deb_cnt, deb_nx;
    logic              hit, push, pop, push_ok, ovf_set;
    logic              fifo_full, fifo_empty;
    logic [7:0]        code_full;
    logic [CODE_W-1:0] push_code;

    // Stage p0/p1: two-flop synchroniser for the asynchronous column lines.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            col_p0 <= '0;
            col_p1 <= '0;
        end else begin
            col_p0 <= COL_IN;
            col_p1 <= col_p0;
        end
    end

    always_comb begin
        hit     = 1'b0;
        hit_col = '0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (col_p1[i]) begin
                hit     = 1'b1;
                hit_col = CW'(i);
            end
        end
        row_adv = (row == RW'(ROWS - 1)) ? '0 : row + RW'(1);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= SCAN;
            row     <= '0;
            col     <= '0;
            div_cnt <= '0;
            deb_cnt <= '0;
        end else begin
            state   <= state_nx;
            row     <= row_nx;
            col     <= col_nx;
            div_cnt <= div_nx;
            deb_cnt <= deb_nx;
        end
    end

    always_comb begin
        state_nx = state;
        row_nx   = row;
        col_nx   = col;
        div_nx   = div_cnt;
        deb_nx   = deb_cnt;
        push     = 1'b0;
        case (state)
            SCAN: begin
                if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
                    div_nx = '0;
                    if (hit) begin
                        col_nx   = hit_col;
                        deb_nx   = '0;
                        state_nx = DEBOUNCE;
                    end else begin
                        row_nx = row_adv;
                    end
                end else begin
                    div_nx = div_cnt + DIV_W'(1);
                end
            end
            DEBOUNCE: begin
                if (!col_p1[col]) begin
                    deb_nx   = '0;
                    row_nx   = row_adv;
                    state_nx = SCAN;
                end else if (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                    push     = 1'b1;
                    deb_nx   = '0;
                    state_nx = HELD;
                end else begin
                    deb_nx = deb_cnt + DEB_W'(1);
                end
            end
            HELD: begin
                // Any column high restarts the release count, so a second key cannot sneak in.
                if (hit) begin
                    deb_nx = '0;
                end else if (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_nx   = '0;
                    row_nx   = row_adv;
                    state_nx = SCAN;
                end else begin
                    deb_nx = deb_cnt + DEB_W'(1);
                end
            end
            default: state_nx = SCAN;
        endcase
    end

    always_comb begin
        ROW_OUT      = '0;
        ROW_OUT[row] = 1'b1;
    end

    assign code_full = code_of(int'(row), int'(col), ROWS, COLS);
    assign push_code = code_full[CODE_W-1:0];

    // A simultaneous pop frees the slot, so a push into a full FIFO is still accepted.
    assign pop     = KEY_ACK & ~fifo_empty;
    assign push_ok = push & (~fifo_full | pop);
    assign ovf_set = push & fifo_full & ~pop;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            INTERUPT <= 1'b0;
            OVERFLOW <= 1'b0;
        end else begin
            INTERUPT <= push_ok;
            OVERFLOW <= ovf_set | (OVERFLOW & ~OVF_CLR);
        end
    end

    key_fifo #(
        .WIDTH (CODE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .wr_en (push_ok),
        .rd_en (pop),
        .din   (push_code),
        .dout  (KEY_CODE),
        .count (FIFO_COUNT),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign KEY_VALID = ~fifo_empty;

endmodule
